// File: rtl/muon_decay_sequencer.sv
// Muon-lifetime start/stop sequencer: edge-detects the coincidence line, times the
// decay window, hands results downstream over valid/ready and keeps run statistics.
module muon_decay_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES  = 2000,
   parameter int unsigned MIN_STOP_CYCLES = 3,
   parameter int unsigned DEADTIME_CYCLES = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        clear_counts,
   input  logic        coincidence,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_time,
   output logic        busy,
   output logic [2:0]  state,
   output logic [31:0] n_starts,
   output logic [31:0] n_decays,
   output logic [31:0] n_timeouts
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_MEASURE = 3'd2,
      S_HOLD    = 3'd3,
      S_DEAD    = 3'd4
   } state_t;

   localparam logic [15:0] TIMEOUT_C   = 16'(TIMEOUT_CYCLES);
   localparam logic [15:0] MIN_STOP_C  = 16'(MIN_STOP_CYCLES);
   localparam logic [31:0] DEAD_LAST_C = 32'(DEADTIME_CYCLES - 1);

   function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic evt,
                                           input logic clr);
      logic [31:0] res;
      if (clr) begin
         res = 32'd0;
      end else if (evt && (cnt != 32'hFFFF_FFFF)) begin
         res = cnt + 32'd1;
      end else begin
         res = cnt;
      end
      return res;
   endfunction

   state_t      state_q, state_d;
   logic        coin_q;
   logic [15:0] elapsed_q, elapsed_d;
   logic [31:0] dead_cnt_q, dead_cnt_d;
   logic [15:0] res_time_q, res_time_d;
   logic        res_valid_q, res_valid_d;
   logic        busy_q, busy_d;
   logic [31:0] n_starts_q, n_decays_q, n_timeouts_q;

   logic        edge_s;
   logic [15:0] n_s;
   logic        stop_ok_s;
   logic        evt_start_s, evt_decay_s, evt_timeout_s;

   assign edge_s    = coincidence & ~coin_q;
   assign n_s       = elapsed_q + 16'd1;
   assign stop_ok_s = edge_s && (n_s >= MIN_STOP_C) && (n_s <= TIMEOUT_C);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_ARMED;
            else        state_d = S_IDLE;
         end
         S_ARMED: begin
            if (!enable)     state_d = S_IDLE;
            else if (edge_s) state_d = S_MEASURE;
            else             state_d = S_ARMED;
         end
         S_MEASURE: begin
            if (!enable)                state_d = S_IDLE;
            else if (stop_ok_s)         state_d = S_HOLD;
            else if (n_s == TIMEOUT_C)  state_d = S_DEAD;
            else                        state_d = S_MEASURE;
         end
         S_HOLD: begin
            if (res_ready) state_d = S_DEAD;
            else           state_d = S_HOLD;
         end
         S_DEAD: begin
            if (dead_cnt_q == DEAD_LAST_C) state_d = enable ? S_ARMED : S_IDLE;
            else                           state_d = S_DEAD;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode, taken from the next state so registered outputs track state_q
   always_comb begin
      res_valid_d = 1'b0;
      busy_d      = 1'b0;
      case (state_d)
         S_MEASURE: busy_d = 1'b1;
         S_HOLD: begin
            busy_d      = 1'b1;
            res_valid_d = 1'b1;
         end
         S_DEAD:  busy_d = 1'b1;
         default: busy_d = 1'b0;
      endcase
   end

   // Window timer, dead-time counter, result capture and count events
   always_comb begin
      elapsed_d     = elapsed_q;
      res_time_d    = res_time_q;
      evt_start_s   = 1'b0;
      evt_decay_s   = 1'b0;
      evt_timeout_s = 1'b0;
      if (state_q == S_DEAD) begin
         dead_cnt_d = dead_cnt_q + 32'd1;
      end else begin
         dead_cnt_d = 32'd0;
      end
      if ((state_q == S_ARMED) && enable && edge_s) begin
         elapsed_d   = 16'd0;
         evt_start_s = 1'b1;
      end else if ((state_q == S_MEASURE) && enable) begin
         elapsed_d = n_s;
         if (stop_ok_s) begin
            res_time_d  = n_s;
            evt_decay_s = 1'b1;
         end else begin
            evt_timeout_s = (n_s == TIMEOUT_C);
         end
      end else begin
         elapsed_d = elapsed_q;
      end
   end

   // Datapath and statistics registers
   always_ff @(posedge clk) begin
      if (rst) begin
         coin_q       <= 1'b1;
         elapsed_q    <= 16'd0;
         dead_cnt_q   <= 32'd0;
         res_time_q   <= 16'd0;
         res_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         n_starts_q   <= 32'd0;
         n_decays_q   <= 32'd0;
         n_timeouts_q <= 32'd0;
      end else begin
         coin_q       <= coincidence;
         elapsed_q    <= elapsed_d;
         dead_cnt_q   <= dead_cnt_d;
         res_time_q   <= res_time_d;
         res_valid_q  <= res_valid_d;
         busy_q       <= busy_d;
         n_starts_q   <= sat_inc(n_starts_q, evt_start_s, clear_counts);
         n_decays_q   <= sat_inc(n_decays_q, evt_decay_s, clear_counts);
         n_timeouts_q <= sat_inc(n_timeouts_q, evt_timeout_s, clear_counts);
      end
   end

   assign state      = state_q;
   assign res_valid  = res_valid_q;
   assign busy       = busy_q;
   assign res_time   = res_time_q;
   assign n_starts   = n_starts_q;
   assign n_decays   = n_decays_q;
   assign n_timeouts = n_timeouts_q;

endmodule

// File: tb/tb_muon_decay_sequencer.sv
// Bench for muon_decay_sequencer: vector table, hand-written corner sequences and
// random stimulus checked against a timestamp-based reference model.
module tb_muon_decay_sequencer;

   localparam int TO = 150;
   localparam int MS = 3;
   localparam int DT = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        clear_counts = 1'b0;
   logic        coincidence = 1'b0;
   logic        res_ready = 1'b0;
   logic        res_valid;
   logic [15:0] res_time;
   logic        busy;
   logic [2:0]  state;
   logic [31:0] n_starts, n_decays, n_timeouts;

   muon_decay_sequencer #(
      .TIMEOUT_CYCLES (TO),
      .MIN_STOP_CYCLES(MS),
      .DEADTIME_CYCLES(DT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .clear_counts(clear_counts),
      .coincidence (coincidence),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_time    (res_time),
      .busy        (busy),
      .state       (state),
      .n_starts    (n_starts),
      .n_decays    (n_decays),
      .n_timeouts  (n_timeouts)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int valid_seen = 0;

   // Reference model: phases plus absolute cycle timestamps
   int          m_mode = 0;        // 0 off, 1 armed, 2 window, 3 result waiting, 4 dead
   longint      m_cyc = 0;
   longint      m_start = 0;
   longint      m_dead_end = 0;
   logic        m_prev = 1'b1;
   int          m_time = 0;
   logic [31:0] m_starts = 32'd0, m_decays = 32'd0, m_touts = 32'd0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, m_cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] bump(input logic [31:0] c, input bit ev);
      if (ev && c != 32'hFFFF_FFFF) return c + 32'd1;
      return c;
   endfunction

   task automatic model_step(input logic r, input logic en, input logic cl,
                             input logic co, input logic rd);
      bit     e, es, ed, et;
      longint n;
      m_cyc++;
      e = co & ~m_prev;
      m_prev = co;
      es = 0; ed = 0; et = 0;
      if (r) begin
         m_mode = 0; m_time = 0; m_prev = 1'b1;
         m_starts = 32'd0; m_decays = 32'd0; m_touts = 32'd0;
      end else begin
         case (m_mode)
            0: if (en) m_mode = 1;
            1: begin
               if (!en) m_mode = 0;
               else if (e) begin m_start = m_cyc; es = 1; m_mode = 2; end
            end
            2: begin
               n = m_cyc - m_start;
               if (!en) m_mode = 0;
               else if (e && n >= MS && n <= TO) begin
                  m_time = int'(n); ed = 1; m_mode = 3;
               end else if (n == TO) begin
                  et = 1; m_mode = 4; m_dead_end = m_cyc + DT;
               end
            end
            3: if (rd) begin m_mode = 4; m_dead_end = m_cyc + DT; end
            4: if (m_cyc == m_dead_end) m_mode = en ? 1 : 0;
            default: m_mode = 0;
         endcase
         if (cl) begin
            m_starts = 32'd0; m_decays = 32'd0; m_touts = 32'd0;
         end else begin
            m_starts = bump(m_starts, es);
            m_decays = bump(m_decays, ed);
            m_touts  = bump(m_touts, et);
         end
      end
   endtask

   task automatic step(input logic r, input logic en, input logic cl,
                       input logic co, input logic rd);
      rst = r; enable = en; clear_counts = cl; coincidence = co; res_ready = rd;
      @(posedge clk);
      model_step(r, en, cl, co, rd);
      #1;
      if (res_valid === 1'b1) valid_seen++;
      chk("m_state", 32'(state), 32'(m_mode));
      chk("m_valid", 32'(res_valid), 32'(m_mode == 3));
      chk("m_busy", 32'(busy), 32'(m_mode >= 2));
      chk("m_time", 32'(res_time), 32'(m_time));
      chk("m_starts", n_starts, m_starts);
      chk("m_decays", n_decays, m_decays);
      chk("m_timeouts", n_timeouts, m_touts);
   endtask

   task automatic run(input int n, input logic en, input logic rd);
      for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, 1'b0, rd);
   endtask

   // Start pulse, then a stop pulse n cycles later
   task automatic window(input int n, input logic rd);
      step(1'b0, 1'b1, 1'b0, 1'b1, rd);
      run(n - 1, 1'b1, rd);
      step(1'b0, 1'b1, 1'b0, 1'b1, rd);
   endtask

   typedef struct {
      logic        en, coin, rdy;
      logic [2:0]  st;
      logic        vld;
      logic [15:0] tm;
      logic [31:0] starts, decays;
   } vec_t;

   vec_t tbl[13];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 16'd0, 32'd0, 32'd0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 16'd0, 32'd0, 32'd0};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 16'd0, 32'd0, 32'd0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 16'd0, 32'd0, 32'd0};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 16'd0, 32'd0, 32'd0};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 16'd0, 32'd1, 32'd0};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 16'd0, 32'd1, 32'd0};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 16'd0, 32'd1, 32'd0};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 16'd0, 32'd1, 32'd0};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 16'd4, 32'd1, 32'd1};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 16'd4, 32'd1, 32'd1};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 16'd4, 32'd1, 32'd1};
      tbl[12] = '{1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 16'd4, 32'd1, 32'd1};

      // Reset with the coincidence line held high
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_time", 32'(res_time), 32'd0);
      chk("rst_starts", n_starts, 32'd0);

      foreach (tbl[i]) begin
         step(1'b0, tbl[i].en, 1'b0, tbl[i].coin, tbl[i].rdy);
         chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
         chk($sformatf("tbl%0d_valid", i), 32'(res_valid), 32'(tbl[i].vld));
         chk($sformatf("tbl%0d_time", i), 32'(res_time), 32'(tbl[i].tm));
         chk($sformatf("tbl%0d_starts", i), n_starts, tbl[i].starts);
         chk($sformatf("tbl%0d_decays", i), n_decays, tbl[i].decays);
      end
      run(DT - 1, 1'b1, 1'b1);
      chk("dead_last", 32'(state), 32'd4);
      run(1, 1'b1, 1'b1);
      chk("dead_rearm", 32'(state), 32'd1);

      // Normal decay, 20 cycles
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("clr_starts", n_starts, 32'd0);
      chk("clr_decays", n_decays, 32'd0);
      valid_seen = 0;
      window(20, 1'b1);
      chk("dec_time", 32'(res_time), 32'd20);
      chk("dec_valid", 32'(res_valid), 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("dec_dead", 32'(state), 32'd4);
      chk("dec_one_valid", 32'(valid_seen), 32'd1);
      chk("dec_starts", n_starts, 32'd1);
      chk("dec_decays", n_decays, 32'd1);
      run(DT, 1'b1, 1'b1);

      // Minimum stop
      window(3, 1'b1);
      chk("min_time", 32'(res_time), 32'd3);
      chk("min_valid", 32'(res_valid), 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      run(DT, 1'b1, 1'b1);

      // Stop on the last window cycle
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      window(TO, 1'b1);
      chk("last_time", 32'(res_time), 32'd150);
      chk("last_timeouts", n_timeouts, 32'd0);
      chk("last_decays", n_decays, 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      run(DT, 1'b1, 1'b1);

      // Timeout, pulse in dead time, restart after re-arm
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      valid_seen = 0;
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      run(TO - 1, 1'b1, 1'b1);
      chk("to_before", n_timeouts, 32'd0);
      run(1, 1'b1, 1'b1);
      chk("to_count", n_timeouts, 32'd1);
      chk("to_dead", 32'(state), 32'd4);
      run(4, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      run(DT - 6, 1'b1, 1'b1);
      chk("to_still_dead", 32'(state), 32'd4);
      run(1, 1'b1, 1'b1);
      chk("to_rearm", 32'(state), 32'd1);
      chk("to_no_valid", 32'(valid_seen), 32'd0);
      chk("to_dead_pulse", n_starts, 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("to_restart", n_starts, 32'd2);

      // Abort mid-window
      run(5, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_starts", n_starts, 32'd2);
      chk("abort_timeouts", n_timeouts, 32'd1);
      chk("abort_decays", n_decays, 32'd0);

      // Clear together with a start edge, then backpressure
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("clrstart_state", 32'(state), 32'd2);
      chk("clrstart_starts", n_starts, 32'd0);
      run(4, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'(i % 2), 1'b0);
      chk("bp_state", 32'(state), 32'd3);
      chk("bp_time", 32'(res_time), 32'd5);
      chk("bp_starts", n_starts, 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("bp_dead", 32'(state), 32'd4);
      chk("bp_valid", 32'(res_valid), 32'd0);
      run(DT, 1'b1, 1'b1);

      // Reset while a result waits
      window(7, 1'b0);
      chk("hold_before_rst", 32'(state), 32'd3);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("hrst_state", 32'(state), 32'd0);
      chk("hrst_valid", 32'(res_valid), 32'd0);
      chk("hrst_busy", 32'(busy), 32'd0);
      chk("hrst_time", 32'(res_time), 32'd0);
      chk("hrst_starts", n_starts, 32'd0);
      chk("hrst_decays", n_decays, 32'd0);

      // Random stimulus against the model
      begin
         logic co;
         co = 1'b0;
         for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) co = ~co;
            step(1'($urandom_range(0, 999) == 0), 1'($urandom_range(0, 31) != 0),
                 1'($urandom_range(0, 99) == 0), co, 1'($urandom_range(0, 3) != 0));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muon_decay_sequencer.md
# muon_decay_sequencer

Control block ahead of the muon-lifetime readout. It watches the scintillator coincidence line and treats a first rising edge as muon arrival (start) and a second rising edge inside the decay window as the decay electron (stop). Each accepted decay interval is handed downstream over a valid/ready handshake; windows with no stop count as timeouts. A dead-time then elapses before the block re-arms. It sits between the coincidence logic and the histogram/UART result path and owns run statistics.

## Interface

Parameters:

- `TIMEOUT_CYCLES`, default 2000: decay window length in clk cycles (20 µs at 100 MHz). Legal range 2..65535.
- `MIN_STOP_CYCLES`, default 3: stop edges arriving earlier than this are ignored (afterpulse rejection). Legal range 1..TIMEOUT_CYCLES.
- `DEADTIME_CYCLES`, default 100: re-arm delay after any completed window. Legal range ≥1.

Ports (clock and reset first):

- `clk` input, 1 bit: system clock, 100 MHz. All logic is on its rising edge. One clock only.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `enable` input, 1 bit: run enable. Low disarms the block.
- `clear_counts` input, 1 bit: synchronous clear of all statistics counters.
- `coincidence` input, 1 bit: coincidence line, already synchronous to clk. Only rising edges are used.
- `res_valid` output, 1 bit: a decay result is available.
- `res_ready` input, 1 bit: the downstream block accepts the result.
- `res_time` output, 16 bits: decay interval in clk cycles.
- `busy` output, 1 bit: high in MEASURE, HOLD and DEAD.
- `state` output, 3 bits: current state encoding, for debug.
- `n_starts` output, 32 bits: count of starts.
- `n_decays` output, 32 bits: count of accepted decays.
- `n_timeouts` output, 32 bits: count of timeouts.

## Operation

- Edge detect:
  - `coin_q` holds the previous sample of `coincidence`.
  - An edge is flagged when `coincidence & ~coin_q`.
  - `coin_q` resets to 1, so a line that is high during reset does not produce an edge.
- State encoding: IDLE=0, ARMED=1, MEASURE=2, HOLD=3, DEAD=4.
- IDLE:
  - Goes to ARMED when `enable`=1.
  - Edges are ignored.
- ARMED:
  - If `enable`=0, go to IDLE.
  - Otherwise an edge sets `elapsed`=0, increments `n_starts` and moves to MEASURE.
- MEASURE:
  - `elapsed` increments once per cycle.
  - Let N = the `elapsed` value after increment in the current cycle (N=1 on the first cycle after the start edge).
  - Priority order, highest first:
    1. `enable`=0: abort. Go to IDLE with no result and no counter change.
    2. Edge with MIN_STOP_CYCLES ≤ N ≤ TIMEOUT_CYCLES: `res_time`←N, `n_decays`++, go to HOLD.
    3. N == TIMEOUT_CYCLES with no qualifying edge: `n_timeouts`++, go to DEAD.
    4. Otherwise stay in MEASURE. An edge with N < MIN_STOP_CYCLES is discarded.
- HOLD:
  - `res_valid`=1. `res_time` is held stable.
  - On `res_valid & res_ready`, go to DEAD.
  - Edges are ignored. `enable` does not abort HOLD.
- DEAD:
  - Counts DEADTIME_CYCLES cycles, then goes to ARMED if `enable`=1, else IDLE.
  - Edges are ignored.
- Counters:
  - 32-bit, saturating at 0xFFFFFFFF.
  - `clear_counts` zeroes all three counters. If a count event happens in the same cycle, clear wins.
  - `clear_counts` does not affect state.
- Reset values:
  - State IDLE.
  - `res_valid`=0, `res_time`=0, `busy`=0, `state`=0.
  - All counters 0, `elapsed`=0.
  - Reset mid-window discards the measurement and any pending result.

## Timing

- Start edge sampled at posedge k, stop edge sampled at posedge k+N: `res_time`=N and `res_valid`=1 are visible right after posedge k+N. Latency is zero cycles beyond the stop sample.
- Timeout: with no stop edge, `n_timeouts` increments at posedge k+TIMEOUT_CYCLES. A stop edge at exactly k+TIMEOUT_CYCLES is a decay, not a timeout.
- Handshake: `res_valid` stays high until a cycle with `res_ready`=1. DEAD begins on the next posedge, and `res_valid` falls in that same update. `res_ready` is ignored while `res_valid`=0.
- DEAD duration: exactly DEADTIME_CYCLES cycles in DEAD, then ARMED. The first edge that can start a new window is sampled in the cycle after that transition.
- A coincidence held high for many cycles produces one edge only.

## Test plan

- Normal decay:
  - Stimulus: defaults, `enable`=1, `res_ready`=1, 1-cycle coincidence pulse, then a second pulse 200 ns (20 cycles) later.
  - Required: `res_time`=20, one `res_valid` cycle, `n_starts`=1, `n_decays`=1.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=150, start pulse, no stop for 2 µs.
  - Required: `n_timeouts`=1 at start+150 cycles, `res_valid` never asserted, ARMED again 100 cycles later.
- Boundaries:
  - Stimulus: stop at N=2, then N=3 (MIN_STOP_CYCLES=3); stop at N=TIMEOUT_CYCLES=150.
  - Required: N=2 edge ignored and the window continues. N=3 accepted with `res_time`=3. N=150 gives `res_time`=150 with `n_timeouts` unchanged.
- Backpressure:
  - Stimulus: `res_ready`=0 for 10 cycles after the stop, with extra coincidence pulses during that time.
  - Required: `res_time` stable, pulses ignored, `n_starts` unchanged, DEAD entered one cycle after `res_ready` rises.
- Late and dead-time edges:
  - Stimulus: start, timeout, a pulse 5 cycles into DEAD, then a pulse after re-arm.
  - Required: the DEAD pulse has no effect. The later pulse starts a new window and `n_starts`=2.
- Abort, clear, reset:
  - Stimulus: drop `enable` mid-MEASURE; assert `clear_counts` in the same cycle as a start edge; assert `rst` during HOLD.
  - Required: abort goes to IDLE with no counter change. Counters read 0 after the clear. After reset, `res_valid`=0 and all outputs are at reset values.
